// File: rtl/ddr3_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_pkg
// Shared DDR3 definitions used by the init initiator and the init responder:
//   - command encodings as {ras_n, cas_n, we_n}
//   - error codes reported by the responder
//   - init state encoding
//   - the mode-register programming order (MR2, MR3, MR1, MR0)
// ---------------------------------------------------------------------------
package ddr3_pkg;

    // Command encodings, {ras_n, cas_n, we_n} with cs_n low.
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_ZQ  = 3'b110;
    localparam logic [2:0] CMD_NOP = 3'b111;

    // Error codes; only the first one seen is latched.
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_RST_CKE   = 3'd1;
    localparam logic [2:0] ERR_MRS_ORDER = 3'd2;
    localparam logic [2:0] ERR_TMRD      = 3'd3;
    localparam logic [2:0] ERR_TMOD      = 3'd4;
    localparam logic [2:0] ERR_ZQ_BUSY   = 3'd5;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd6;

    typedef enum logic [2:0] {
        ST_WAIT_RST = 3'd0,
        ST_WAIT_CKE = 3'd1,
        ST_WAIT_MRS = 3'd2,
        ST_WAIT_ZQ  = 3'd3,
        ST_ZQ_BUSY  = 3'd4,
        ST_READY    = 3'd5
    } init_state_t;

    localparam int GAP_W = 16;
    localparam int ZQ_W  = 16;

    // Bank address expected for the idx-th MRS of the init sequence.
    function automatic logic [2:0] mrs_order_ba(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            2'd2:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ddr3_timing_check.sv
// ---------------------------------------------------------------------------
// ddr3_timing_check
// Tracks the spacing between consecutive commands and flags tMRD / tMOD
// violations for the command presented this cycle.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   is_cmd       a non-NOP command is sampled this cycle
//   is_mrs       that command is an MRS
//   tmrd_viol    MRS following an MRS with gap < TMRD (combinational)
//   tmod_viol    non-MRS following an MRS with gap < TMOD (combinational)
//
// The gap is the distance in cycles between two commands: back-to-back
// commands have gap 1. The counter holds the number of idle cycles since the
// last command, so the gap is that count plus one (saturating).
// ---------------------------------------------------------------------------
module ddr3_timing_check
    import ddr3_pkg::*;
#(
    parameter int TMRD = 4,
    parameter int TMOD = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic is_cmd,
    input  logic is_mrs,
    output logic tmrd_viol,
    output logic tmod_viol
);

    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    localparam logic [GAP_W-1:0] TMRD_GAP = GAP_W'(TMRD);
    localparam logic [GAP_W-1:0] TMOD_GAP = GAP_W'(TMOD);

    logic [GAP_W-1:0] gap_cnt_reg;
    logic [GAP_W-1:0] gap;
    logic             last_mrs_reg;

    assign gap = (gap_cnt_reg == GAP_MAX) ? GAP_MAX : gap_cnt_reg + GAP_W'(1);

    assign tmrd_viol = is_cmd &&  is_mrs && last_mrs_reg && (gap < TMRD_GAP);
    assign tmod_viol = is_cmd && !is_mrs && last_mrs_reg && (gap < TMOD_GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_reg  <= '0;
            last_mrs_reg <= 1'b0;
        end else if (is_cmd) begin
            gap_cnt_reg  <= '0;
            last_mrs_reg <= is_mrs;
        end else if (gap_cnt_reg != GAP_MAX) begin
            gap_cnt_reg  <= gap_cnt_reg + GAP_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_init_responder.sv
// ---------------------------------------------------------------------------
// ddr3_init_responder
// Device-side model of the DDR3 power-up/init protocol. Watches the command
// pins, captures mode registers, tracks the init sequence
// (RST_N -> CKE -> MR2/MR3/MR1/MR0 -> ZQCL -> tZQinit) and latches the first
// protocol error seen.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rst_n_in                 DDR3 RST_N from the initiator
//   cke                      DDR3 CKE
//   cs_n, ras_n, cas_n, we_n command pins
//   ba[2:0], addr[13:0]      bank / address buses
//   mr0..mr3[13:0]           captured mode registers
//   init_done                high while the sequence has completed (READY)
//   cmd_valid, cmd_code[2:0] one-cycle registered echo of each command
//   err, err_code[2:0]       sticky first-error flag and its code
// ---------------------------------------------------------------------------
module ddr3_init_responder
    import ddr3_pkg::*;
#(
    parameter int TMRD    = 4,
    parameter int TMOD    = 12,
    parameter int TZQINIT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_n_in,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [2:0]  ba,
    input  logic [13:0] addr,
    output logic [13:0] mr0,
    output logic [13:0] mr1,
    output logic [13:0] mr2,
    output logic [13:0] mr3,
    output logic        init_done,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam logic [ZQ_W-1:0] ZQ_LOAD = ZQ_W'(TZQINIT - 1);

    init_state_t     state_reg;
    logic [1:0]      mrs_idx_reg;
    logic [ZQ_W-1:0] zq_cnt_reg;
    logic [13:0]     mr_reg [4];
    logic            cmd_valid_reg;
    logic [2:0]      cmd_code_reg;
    logic            err_reg;
    logic [2:0]      err_code_reg;

    // ---------------- command decode ----------------
    logic [2:0] cmd_bits;
    logic       is_cmd;
    logic       is_mrs;
    logic       is_zqcl;
    logic [2:0] exp_ba;

    assign cmd_bits = {ras_n, cas_n, we_n};
    assign is_cmd   = !cs_n && (cmd_bits != CMD_NOP);
    assign is_mrs   = is_cmd && (cmd_bits == CMD_MRS);
    assign is_zqcl  = is_cmd && (cmd_bits == CMD_ZQ) && addr[10];
    assign exp_ba   = mrs_order_ba(mrs_idx_reg);

    // ---------------- timing checks ----------------
    logic tmrd_viol;
    logic tmod_viol;

    ddr3_timing_check #(
        .TMRD (TMRD),
        .TMOD (TMOD)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .is_cmd    (is_cmd),
        .is_mrs    (is_mrs),
        .tmrd_viol (tmrd_viol),
        .tmod_viol (tmod_viol)
    );

    // ---------------- error detection and priority ----------------
    logic       e_rst_cke;
    logic       e_zq_busy;
    logic       e_order;
    logic       e_illegal;
    logic       err_hit;
    logic [2:0] err_now;

    assign e_rst_cke = is_cmd && !(rst_n_in && cke);
    assign e_zq_busy = is_cmd && (state_reg == ST_ZQ_BUSY);
    assign e_order   = is_mrs && (state_reg == ST_WAIT_MRS) && (ba != exp_ba);
    assign e_illegal = is_cmd && (((state_reg == ST_WAIT_MRS) && !is_mrs) ||
                                  ((state_reg == ST_WAIT_ZQ)  && !is_zqcl));

    always_comb begin
        err_hit = 1'b1;
        err_now = ERR_NONE;
        if (e_rst_cke)      err_now = ERR_RST_CKE;
        else if (e_zq_busy) err_now = ERR_ZQ_BUSY;
        else if (e_order)   err_now = ERR_MRS_ORDER;
        else if (e_illegal) err_now = ERR_ILLEGAL;
        else if (tmrd_viol) err_now = ERR_TMRD;
        else if (tmod_viol) err_now = ERR_TMOD;
        else                err_hit = 1'b0;
    end

    // ---------------- init FSM ----------------
    // Commands only advance the sequence or load mode registers while CKE is
    // high; a command with CKE low is reported (code 1) and otherwise ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_WAIT_RST;
            mrs_idx_reg   <= '0;
            zq_cnt_reg    <= '0;
            for (int i = 0; i < 4; i++) mr_reg[i] <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_code_reg  <= CMD_NOP;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            cmd_valid_reg <= is_cmd;
            if (is_cmd) cmd_code_reg <= cmd_bits;

            if (err_hit && !err_reg) begin
                err_reg      <= 1'b1;
                err_code_reg <= err_now;
            end

            if (!rst_n_in) begin
                // Device reset: restart the sequence, keep mode registers.
                state_reg   <= ST_WAIT_RST;
                mrs_idx_reg <= '0;
                zq_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_WAIT_RST: state_reg <= ST_WAIT_CKE;
                    ST_WAIT_CKE: if (cke) state_reg <= ST_WAIT_MRS;
                    ST_WAIT_MRS: begin
                        if (is_mrs && cke && (ba == exp_ba)) begin
                            mr_reg[ba[1:0]] <= addr;
                            mrs_idx_reg     <= mrs_idx_reg + 2'd1;
                            if (mrs_idx_reg == 2'd3) state_reg <= ST_WAIT_ZQ;
                        end
                    end
                    ST_WAIT_ZQ: begin
                        if (is_zqcl && cke) begin
                            state_reg  <= ST_ZQ_BUSY;
                            zq_cnt_reg <= ZQ_LOAD;
                        end
                    end
                    ST_ZQ_BUSY: begin
                        if (zq_cnt_reg == '0) state_reg  <= ST_READY;
                        else                  zq_cnt_reg <= zq_cnt_reg - ZQ_W'(1);
                    end
                    ST_READY: begin
                        if (is_mrs && cke) mr_reg[ba[1:0]] <= addr;
                    end
                    default: state_reg <= ST_WAIT_RST;
                endcase
            end
        end
    end

    assign mr0       = mr_reg[0];
    assign mr1       = mr_reg[1];
    assign mr2       = mr_reg[2];
    assign mr3       = mr_reg[3];
    assign init_done = (state_reg == ST_READY);
    assign cmd_valid = cmd_valid_reg;
    assign cmd_code  = cmd_code_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_ddr3_init_responder.sv
// ---------------------------------------------------------------------------
// tb_ddr3_init_responder
// Drives directed and randomized DDR3 init traffic into ddr3_init_responder.
// A transaction-level reference model predicts the response of every
// command; the prediction is queued and a negedge monitor pops and compares
// it whenever the DUT shows cmd_valid. init_done is compared every cycle.
// ---------------------------------------------------------------------------
module tb_ddr3_init_responder;

    localparam int TMRD    = 4;
    localparam int TMOD    = 12;
    localparam int TZQINIT = 512;

    localparam int PH_RST   = 0;
    localparam int PH_CKE   = 1;
    localparam int PH_MRS   = 2;
    localparam int PH_ZQ    = 3;
    localparam int PH_BUSY  = 4;
    localparam int PH_READY = 5;

    // Error codes in priority order (highest first).
    localparam int PRI [6] = '{1, 5, 2, 6, 3, 4};

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rst_n_in = 1'b0;
    logic        cke      = 1'b0;
    logic        cs_n     = 1'b1;
    logic        ras_n    = 1'b1;
    logic        cas_n    = 1'b1;
    logic        we_n     = 1'b1;
    logic [2:0]  ba       = '0;
    logic [13:0] addr     = '0;
    logic [13:0] mr0, mr1, mr2, mr3;
    logic        init_done, cmd_valid, err;
    logic [2:0]  cmd_code, err_code;

    always #5 clk = ~clk;

    ddr3_init_responder #(
        .TMRD    (TMRD),
        .TMOD    (TMOD),
        .TZQINIT (TZQINIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_n_in  (rst_n_in),
        .cke       (cke),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .ba        (ba),
        .addr      (addr),
        .mr0       (mr0),
        .mr1       (mr1),
        .mr2       (mr2),
        .mr3       (mr3),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .err       (err),
        .err_code  (err_code)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] code;
        logic       err;
        logic [2:0] ecode;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          m_phase;
    int          m_exp_ba[$];
    logic [13:0] m_mr [4];
    logic        m_err;
    logic [2:0]  m_code;
    int          m_last_cyc;
    bit          m_last_mrs;
    int          m_zq_cyc;
    bit          m_init_done;

    task automatic model_reset();
        m_phase     = PH_RST;
        m_exp_ba    = {2, 3, 1, 0};
        for (int i = 0; i < 4; i++) m_mr[i] = '0;
        m_err       = 1'b0;
        m_code      = '0;
        m_last_cyc  = 0;
        m_last_mrs  = 0;
        m_zq_cyc    = 0;
        m_init_done = 0;
        sb_q.delete();
    endtask

    // Applies the inputs sampled at this rising edge to the model.
    task automatic model_edge();
        bit         is_cmd;
        logic [2:0] c;
        bit         hit [6];
        int         gap;
        exp_t       e;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            c      = {ras_n, cas_n, we_n};
            is_cmd = !cs_n && (c != 3'b111);
            if (is_cmd) begin
                gap    = cyc - m_last_cyc;
                hit[0] = !(rst_n_in && cke);
                hit[1] = (m_phase == PH_BUSY);
                hit[2] = 0;
                if (m_phase == PH_MRS && c == 3'b000) hit[2] = (int'(ba) != m_exp_ba[0]);
                hit[3] = (m_phase == PH_MRS && c != 3'b000) ||
                         (m_phase == PH_ZQ && !(c == 3'b110 && addr[10]));
                hit[4] = (c == 3'b000) && m_last_mrs && (gap < TMRD);
                hit[5] = (c != 3'b000) && m_last_mrs && (gap < TMOD);
                if (!m_err) begin
                    for (int i = 0; i < 6; i++) begin
                        if (hit[i]) begin
                            m_err  = 1'b1;
                            m_code = 3'(PRI[i]);
                            break;
                        end
                    end
                end
                m_last_cyc = cyc;
                m_last_mrs = (c == 3'b000);
                e.code  = c;
                e.err   = m_err;
                e.ecode = m_code;
                sb_q.push_back(e);
            end
            if (!rst_n_in) begin
                m_phase  = PH_RST;
                m_exp_ba = {2, 3, 1, 0};
            end else begin
                case (m_phase)
                    PH_RST: m_phase = PH_CKE;
                    PH_CKE: if (cke) m_phase = PH_MRS;
                    PH_MRS: begin
                        if (is_cmd && cke && c == 3'b000 && int'(ba) == m_exp_ba[0]) begin
                            m_mr[ba[1:0]] = addr;
                            void'(m_exp_ba.pop_front());
                            if (m_exp_ba.size() == 0) m_phase = PH_ZQ;
                        end
                    end
                    PH_ZQ: begin
                        if (is_cmd && cke && c == 3'b110 && addr[10]) begin
                            m_phase  = PH_BUSY;
                            m_zq_cyc = cyc;
                        end
                    end
                    PH_BUSY: if (cyc - m_zq_cyc >= TZQINIT) m_phase = PH_READY;
                    PH_READY: if (is_cmd && cke && c == 3'b000) m_mr[ba[1:0]] = addr;
                    default: ;
                endcase
            end
            m_init_done = (m_phase == PH_READY);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (cmd_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_cmd_valid", 32'(cmd_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("cmd_code", 32'(cmd_code), 32'(e.code));
                check("err",      32'(err),      32'(e.err));
                check("err_code", 32'(err_code), 32'(e.ecode));
            end
        end else if (sb_q.size() != 0) begin
            check("missing_cmd_valid", 32'(cmd_valid), 32'd1);
            sb_q.delete();
        end
        check("init_done", 32'(init_done), 32'(m_init_done));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic c_n, input logic [2:0] c, input logic [2:0] b,
                        input logic [13:0] a);
        cs_n = c_n;
        {ras_n, cas_n, we_n} = c;
        ba   = b;
        addr = a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // NOP cycles: either deselect with random pins, or select with 3'b111.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0)
                step(1'b1, 3'($urandom), 3'($urandom), 14'($urandom));
            else
                step(1'b0, 3'b111, 3'($urandom), 14'($urandom));
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [13:0] a);
        step(1'b0, c, b, a);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_mr0", 32'(mr0), 32'd0);
        check("rst_mr1", 32'(mr1), 32'd0);
        check("rst_mr2", 32'(mr2), 32'd0);
        check("rst_mr3", 32'(mr3), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd7);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_outputs();
    endtask

    task automatic bring_up();
        rst_n_in = 1'b0;
        cke      = 1'b0;
        idle(3);
        rst_n_in = 1'b1;
        idle(2);
        cke = 1'b1;
        idle(2);
    endtask

    task automatic check_mrs(input string tag);
        check({tag, "_mr0"}, 32'(mr0), 32'(m_mr[0]));
        check({tag, "_mr1"}, 32'(mr1), 32'(m_mr[1]));
        check({tag, "_mr2"}, 32'(mr2), 32'(m_mr[2]));
        check({tag, "_mr3"}, 32'(mr3), 32'(m_mr[3]));
    endtask

    task automatic zqcl();
        issue(3'b110, 3'($urandom), 14'($urandom) | 14'h0400);
    endtask

    // MR2, MR3, MR1, MR0 at the given spacing, then ZQCL after tMOD.
    task automatic init_seq(input logic [13:0] a0, input int gap);
        issue(3'b000, 3'd2, 14'($urandom)); idle(gap - 1);
        issue(3'b000, 3'd3, 14'($urandom)); idle(gap - 1);
        issue(3'b000, 3'd1, 14'($urandom)); idle(gap - 1);
        issue(3'b000, 3'd0, a0);            idle(TMOD - 1);
        zqcl();
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!init_done && n < budget) begin
            idle(1);
            n++;
        end
        if (!init_done) check("init_done_timeout", 32'(init_done), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int          zq_c;
        logic [13:0] m1;
        logic [2:0]  c;
        logic [2:0]  b;
        logic [13:0] a;

        model_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_reset_outputs();

        // Legal init sequence, then random legal traffic in READY.
        bring_up();
        init_seq(14'h0512, 12);
        zq_c = cyc;
        wait_ready(TZQINIT + 20);
        check("legal_zq_cycles", 32'(cyc - zq_c), 32'(TZQINIT));
        check("legal_mr0", 32'(mr0), 32'h0512);
        check("legal_err", 32'(err), 32'd0);
        check_mrs("legal");
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(TMOD - 1, TMOD + 6));
            issue(3'($urandom_range(0, 6)), 3'($urandom), 14'($urandom));
        end
        idle(2);
        check("ready_err", 32'(err), 32'd0);
        check_mrs("ready");

        // MRS order error: MR3 first.
        do_reset();
        bring_up();
        issue(3'b000, 3'd3, 14'h1abc);
        check("order_err", 32'(err), 32'd1);
        check("order_code", 32'(err_code), 32'd2);
        check("order_mr3", 32'(mr3), 32'd0);
        idle(11);
        issue(3'b000, 3'd2, 14'h0155);
        check("order_mr2_after", 32'(mr2), 32'h0155);
        check("order_init_done", 32'(init_done), 32'd0);

        // tMRD violation, then a later tMOD/illegal ACT stays masked.
        do_reset();
        bring_up();
        issue(3'b000, 3'd2, 14'($urandom)); idle(1);
        issue(3'b000, 3'd3, 14'($urandom));
        check("tmrd_code", 32'(err_code), 32'd3);
        idle(11); issue(3'b000, 3'd1, 14'($urandom));
        idle(11); issue(3'b000, 3'd0, 14'($urandom));
        idle(4);  issue(3'b011, 3'd0, 14'($urandom));
        check("tmrd_sticky", 32'(err_code), 32'd3);

        // Command 100 cycles into ZQ busy.
        do_reset();
        bring_up();
        init_seq(14'($urandom), 12);
        zq_c = cyc;
        idle(99);
        issue(3'($urandom_range(0, 6)), 3'($urandom), 14'($urandom));
        check("zqbusy_code", 32'(err_code), 32'd5);
        wait_ready(TZQINIT + 20);
        check("zqbusy_ready_cycles", 32'(cyc - zq_c), 32'(TZQINIT));

        // RST_N drop after MR1, then a full restart.
        do_reset();
        bring_up();
        m1 = 14'($urandom);
        issue(3'b000, 3'd2, 14'($urandom)); idle(11);
        issue(3'b000, 3'd3, 14'($urandom)); idle(11);
        issue(3'b000, 3'd1, m1);            idle(3);
        rst_n_in = 1'b0;
        idle(1);
        check("rstn_init_done", 32'(init_done), 32'd0);
        check("rstn_mr1", 32'(mr1), 32'(m1));
        rst_n_in = 1'b1;
        idle(2);
        init_seq(14'($urandom), 12);
        wait_ready(TZQINIT + 20);
        check("restart_init_done", 32'(init_done), 32'd1);
        check("restart_err", 32'(err), 32'd0);
        check_mrs("restart");

        // rst in the middle of ZQ busy.
        do_reset();
        bring_up();
        init_seq(14'($urandom), 12);
        idle(50);
        do_reset();

        // Randomized protocol traffic, mostly legal with random faults.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            bring_up();
            for (int k = 0; k < 40; k++) begin
                idle($urandom_range(0, 14));
                c = 3'($urandom_range(0, 6));
                b = 3'($urandom);
                a = 14'($urandom);
                if ($urandom_range(0, 9) < 7) begin
                    if (m_phase == PH_MRS) begin
                        c = 3'b000;
                        b = 3'(m_exp_ba[0]);
                    end else if (m_phase == PH_ZQ) begin
                        c = 3'b110;
                        a = a | 14'h0400;
                    end
                end
                cke      = ($urandom_range(0, 19) != 0);
                rst_n_in = ($urandom_range(0, 29) != 0);
                issue(c, b, a);
                cke      = 1'b1;
                rst_n_in = 1'b1;
            end
            idle(2);
            check("rand_err", 32'(err), 32'(m_err));
            check("rand_err_code", 32'(err_code), 32'(m_code));
            check_mrs("rand");
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "time limit");
    end

endmodule
